usb_kbd_frame_rx: RTL and testbench
===================================

// Module: usb_kbd_frame_rx
// PURPOSE
//  Receives 11-bit keyboard frames over the two-wire USB/PS2-style port after the two-flop synchronizer
//  stage. Samples KDAT on falling KCLK edges and checks start, odd parity and stop bits. Pushes good
//  bytes into a small FIFO drained by the scan-code decoder over a VALID/READY handshake.
//  A watchdog aborts stalled frames.
// PARAMETERS
//  DEPTH        4      FIFO entries; power of 2, >=2
//  TIMEOUT_CYC  5000   CLK cycles allowed between KCLK falling edges inside a frame
// PORTS
//  CLK        in   1  system clock
//  ACLR_L     in   1  asynchronous reset, active low
//  KCLK_SYNC  in   1  keyboard clock, already synchronized to CLK
//  KDAT_SYNC  in   1  keyboard data, already synchronized to CLK
//  DOUT       out  8  received byte at FIFO head
//  VALID      out  1  FIFO non-empty
//  READY      in   1  consumer accepts DOUT this cycle
//  ERR        out  1  1-cycle pulse: parity, stop or timeout error, frame discarded
//  OVF        out  1  1-cycle pulse: good frame dropped because FIFO full
// BEHAVIOUR
//  Reset: all state asynchronously cleared on ACLR_L=0.
//   DOUT=0, VALID=0, ERR=0, OVF=0, FIFO empty, FSM=IDLE.
//   The edge-detect register resets to 1 (idle-high line), so no false edge occurs after reset.
//  Edge detect: fall = kclk_q & ~KCLK_SYNC, where kclk_q is KCLK_SYNC delayed one CLK.
//   Only fall cycles sample KDAT_SYNC.
//  FSM states and transitions:
//   IDLE   fall & KDAT=0 -> DATA, bitcnt=0. fall & KDAT=1 -> stay IDLE (glitch, no ERR).
//   DATA   on fall: shift KDAT in, LSB first. After the 8th bit -> PARITY.
//   PARITY on fall: capture parity bit -> STOP.
//   STOP   on fall: good frame requires (popcount(data)+parity odd) and KDAT=1.
//          Good frame: push byte to FIFO, or pulse OVF if full. Bad frame: pulse ERR. Then -> IDLE.
//  Watchdog: counter cleared on every fall and held at 0 in IDLE.
//   In DATA/PARITY/STOP, reaching TIMEOUT_CYC-1 without a fall -> ERR pulse, partial frame discarded,
//   FSM -> IDLE.
//  FIFO: circular buffer, log2(DEPTH)+1-bit rd/wr pointers (MSB is the wrap bit).
//   empty = ptrs equal; full = low bits equal and MSBs differ.
//   Push is visible on VALID/DOUT the cycle after the STOP fall (1-cycle latency from the stop edge).
//   DOUT = mem[rd_ptr]; DOUT is 0 when empty.
//   Pop happens when VALID & READY; DOUT must stay stable while VALID & ~READY.
//   Push and pop in the same cycle: both take effect; a full FIFO with a pop accepts the push, no OVF.
//  Outputs are registered. ERR and OVF are never both asserted in the same cycle.
//  Reset mid-frame: frame lost, FIFO contents lost, no ERR pulse.
// TESTING
//  1 Frame 0x1C (start0, bits LSB-first, parity0, stop1), READY=1 -> VALID for 1 cycle, DOUT=0x1C,
//    ERR=0.
//  2 Frame 0xF0 with parity 0 (bad) -> ERR one pulse, VALID stays 0. Next good frame 0xF0 with
//    parity 1 -> DOUT=0xF0.
//  3 READY=0, send frames 0x01..0x05 with DEPTH=4 -> VALID=1, DOUT=0x01, OVF pulse on the 5th frame.
//    Then READY=1 -> drains 01,02,03,04.
//  4 Stop KCLK after 4 data bits for TIMEOUT_CYC cycles -> ERR pulse, FSM IDLE.
//    Following frame 0x5A is received correctly.
//  5 FIFO full, READY=1 on the exact cycle a new frame completes -> no OVF, FIFO stays full,
//    order preserved.
//  6 Assert ACLR_L=0 after 6 bits of a frame with 2 bytes queued -> VALID=0, DOUT=0, no ERR.
//    Next frame 0x33 is received cleanly.

Source files
------------

// File: rtl/usb_kbd_frame_rx.sv
// Keyboard frame receiver: samples KDAT on KCLK falls, checks start/odd parity/stop,
// queues good bytes in a small FIFO with a watchdog aborting stalled frames.
module usb_kbd_frame_rx #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       CLK,
  input  logic       ACLR_L,
  input  logic       KCLK_SYNC,
  input  logic       KDAT_SYNC,
  output logic [7:0] DOUT,
  output logic       VALID,
  input  logic       READY,
  output logic       ERR,
  output logic       OVF
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state_reg;
  logic            kclk_q_reg;
  logic [7:0]      shift_reg;
  logic [2:0]      bitcnt_reg;
  logic            parity_reg;
  logic [WDW-1:0]  wd_cnt_reg;
  logic [7:0]      mem_reg [DEPTH];
  logic [AW:0]     wr_ptr_reg, rd_ptr_reg;

  logic            fall, stop_fall, frame_good, frame_bad, timeout;
  logic            full, empty, pop, push, ovf_next;
  logic [AW:0]     wr_ptr_next, rd_ptr_next;
  logic [AW-1:0]   head_idx;
  logic [7:0]      dout_next;

  assign fall       = kclk_q_reg & ~KCLK_SYNC;
  assign stop_fall  = (state_reg == STOP) & fall;
  // XOR over data and parity is 1 exactly when the total count of ones is odd
  assign frame_good = stop_fall & (^{shift_reg, parity_reg}) & KDAT_SYNC;
  assign frame_bad  = stop_fall & ~frame_good;
  assign timeout    = (state_reg != IDLE) & ~fall & (wd_cnt_reg == WDW'(TIMEOUT_CYC - 1));

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) & (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign pop      = ~empty & READY;
  assign push     = frame_good & (~full | pop);
  assign ovf_next = frame_good & full & ~pop;

  assign wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, push};
  assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop};
  assign head_idx    = rd_ptr_next[AW-1:0];

  // Head after this edge: the byte being written bypasses the array when it lands at the head
  always_comb begin
    dout_next = 8'h00;
    if (wr_ptr_next != rd_ptr_next) begin
      if (push && (head_idx == wr_ptr_reg[AW-1:0]))
        dout_next = shift_reg;
      else
        dout_next = mem_reg[head_idx];
    end
  end

  always_ff @(posedge CLK or negedge ACLR_L) begin
    if (!ACLR_L) begin
      state_reg  <= IDLE;
      kclk_q_reg <= 1'b1;
      shift_reg  <= 8'h00;
      bitcnt_reg <= 3'd0;
      parity_reg <= 1'b0;
      wd_cnt_reg <= '0;
      ERR        <= 1'b0;
    end else begin
      kclk_q_reg <= KCLK_SYNC;
      ERR        <= frame_bad | timeout;
      if (state_reg == IDLE || fall)
        wd_cnt_reg <= '0;
      else if (!timeout)
        wd_cnt_reg <= wd_cnt_reg + 1'b1;

      case (state_reg)
        IDLE: begin
          if (fall && !KDAT_SYNC) begin
            state_reg  <= DATA;
            bitcnt_reg <= 3'd0;
          end
        end
        DATA: begin
          if (fall) begin
            shift_reg  <= {KDAT_SYNC, shift_reg[7:1]};
            bitcnt_reg <= bitcnt_reg + 3'd1;
            if (bitcnt_reg == 3'd7)
              state_reg <= PARITY;
          end else if (timeout) begin
            state_reg <= IDLE;
          end
        end
        PARITY: begin
          if (fall) begin
            parity_reg <= KDAT_SYNC;
            state_reg  <= STOP;
          end else if (timeout) begin
            state_reg <= IDLE;
          end
        end
        STOP: begin
          if (fall || timeout)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge ACLR_L) begin
    if (!ACLR_L) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      DOUT       <= 8'h00;
      VALID      <= 1'b0;
      OVF        <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      DOUT       <= dout_next;
      VALID      <= (wr_ptr_next != rd_ptr_next);
      OVF        <= ovf_next;
    end
  end

  // Storage needs no reset: pointers define what is valid
  always_ff @(posedge CLK) begin
    if (push)
      mem_reg[wr_ptr_reg[AW-1:0]] <= shift_reg;
  end

endmodule

// File: tb/tb_usb_kbd_frame_rx.sv
// Directed bench for usb_kbd_frame_rx: frame-level model with per-cycle output compare.
module tb_usb_kbd_frame_rx;

  localparam int DEPTH = 4;
  localparam int TMO   = 60;
  localparam int HALF  = 5;

  logic       CLK = 1'b0;
  logic       ACLR_L = 1'b0;
  logic       KCLK_SYNC = 1'b1;
  logic       KDAT_SYNC = 1'b1;
  logic       READY = 1'b0;
  logic [7:0] DOUT;
  logic       VALID, ERR, OVF;

  int n_total = 0;
  int n_bad   = 0;

  always #5 CLK = ~CLK;

  usb_kbd_frame_rx #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .ACLR_L(ACLR_L), .KCLK_SYNC(KCLK_SYNC), .KDAT_SYNC(KDAT_SYNC),
    .DOUT(DOUT), .VALID(VALID), .READY(READY), .ERR(ERR), .OVF(OVF)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: collects frame bits, judges whole frames, keeps the FIFO as a queue
  byte unsigned mq[$];
  bit   m_err = 0, m_ovf = 0;
  bit   m_prevk = 1, m_in = 0;
  int   m_nbits = 0, m_quiet = 0;
  bit   m_bits[10];

  always @(posedge CLK or negedge ACLR_L) begin : model
    bit fall, pop, pushreq;
    logic [7:0] d;
    if (!ACLR_L) begin
      mq.delete();
      m_prevk = 1; m_in = 0; m_err = 0; m_ovf = 0; m_nbits = 0; m_quiet = 0;
    end else begin
      fall    = m_prevk && !KCLK_SYNC;
      m_prevk = KCLK_SYNC;
      pop     = (mq.size() != 0) && READY;
      pushreq = 0;
      m_err   = 0;
      m_ovf   = 0;
      d       = 8'h00;
      if (!m_in) begin
        if (fall && !KDAT_SYNC) begin
          m_in = 1; m_nbits = 0; m_quiet = 0;
        end
      end else if (fall) begin
        m_quiet = 0;
        m_bits[m_nbits] = KDAT_SYNC;
        m_nbits++;
        if (m_nbits == 10) begin
          for (int i = 0; i < 8; i++) d[i] = m_bits[i];
          m_in = 0;
          if ((($countones(d) + int'(m_bits[8])) % 2 == 1) && m_bits[9]) pushreq = 1;
          else m_err = 1;
        end
      end else begin
        m_quiet++;
        if (m_quiet == TMO) begin
          m_err = 1; m_in = 0;
        end
      end
      if (pop) void'(mq.pop_front());
      if (pushreq) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1;
      end
    end
  end

  int err_cnt = 0, ovf_cnt = 0, valid_cyc = 0;
  byte unsigned log_q[$];

  always @(negedge CLK) begin
    check("valid", int'(VALID), (mq.size() != 0) ? 1 : 0);
    check("dout", int'(DOUT), (mq.size() != 0) ? int'(mq[0]) : 0);
    check("err", int'(ERR), int'(m_err));
    check("ovf", int'(OVF), int'(m_ovf));
    if (ACLR_L) begin
      if (ERR) err_cnt++;
      if (OVF) ovf_cnt++;
      if (VALID) valid_cyc++;
      if (VALID && READY) log_q.push_back(DOUT);
    end
  end

  function automatic int logged(input int i);
    return (log_q.size() > i) ? int'(log_q[i]) : -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input bit good);
    logic par;
    par = good ? ~^d : ^d;
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] fr, input int nf, input bit rdy_at_stop);
    for (int i = 0; i < nf; i++) begin
      KDAT_SYNC = fr[i];
      KCLK_SYNC = 1'b1;
      tick(HALF);
      KCLK_SYNC = 1'b0;
      if (rdy_at_stop && i == 10) READY = 1'b1;
      tick(1);
      if (rdy_at_stop && i == 10) READY = 1'b0;
      tick(HALF - 1);
    end
    KCLK_SYNC = 1'b1;
    KDAT_SYNC = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input bit good);
    send_bits(frame(d, good), 11, 1'b0);
    tick(20);
  endtask

  initial begin
    #500000;
    $display("FAIL bench_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int e0, o0, v0;
    tick(4);
    check("rst_valid", int'(VALID), 0);
    check("rst_dout", int'(DOUT), 0);
    check("rst_err", int'(ERR), 0);
    ACLR_L = 1'b1;
    tick(4);

    // 1: single good frame
    READY = 1'b1; log_q.delete(); e0 = err_cnt; v0 = valid_cyc;
    send(8'h1C, 1'b1);
    check("t1_cnt", log_q.size(), 1);
    check("t1_byte", logged(0), 'h1C);
    check("t1_vcyc", valid_cyc - v0, 1);
    check("t1_err", err_cnt - e0, 0);

    // 2: bad parity then good
    log_q.delete(); e0 = err_cnt;
    send(8'hF0, 1'b0);
    check("t2_err", err_cnt - e0, 1);
    check("t2_none", log_q.size(), 0);
    send(8'hF0, 1'b1);
    check("t2_byte", logged(0), 'hF0);

    // 3: overflow with READY low
    READY = 1'b0; log_q.delete(); o0 = ovf_cnt;
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
    check("t3_valid", int'(VALID), 1);
    check("t3_head", int'(DOUT), 'h01);
    check("t3_ovf", ovf_cnt - o0, 1);
    READY = 1'b1;
    tick(10);
    check("t3_cnt", log_q.size(), 4);
    for (int i = 0; i < 4; i++) check("t3_drain", logged(i), i + 1);

    // 4: stalled frame hits the watchdog
    log_q.delete(); e0 = err_cnt;
    send_bits(frame(8'hA5, 1'b1), 5, 1'b0);
    tick(TMO + 10);
    check("t4_err", err_cnt - e0, 1);
    send(8'h5A, 1'b1);
    check("t4_byte", logged(0), 'h5A);
    check("t4_cnt", log_q.size(), 1);

    // 5: full FIFO popped on the exact stop edge
    READY = 1'b0; log_q.delete(); o0 = ovf_cnt;
    send(8'h11, 1'b1); send(8'h22, 1'b1); send(8'h33, 1'b1); send(8'h44, 1'b1);
    send_bits(frame(8'h55, 1'b1), 11, 1'b1);
    tick(5);
    check("t5_ovf", ovf_cnt - o0, 0);
    check("t5_head", int'(DOUT), 'h22);
    READY = 1'b1;
    tick(10);
    check("t5_cnt", log_q.size(), 5);
    for (int i = 0; i < 5; i++) check("t5_order", logged(i), 'h11 * (i + 1));

    // 6: reset mid-frame with bytes queued
    READY = 1'b0; log_q.delete(); e0 = err_cnt;
    send(8'h66, 1'b1); send(8'h77, 1'b1);
    send_bits(frame(8'h12, 1'b1), 7, 1'b0);
    ACLR_L = 1'b0;
    tick(1);
    check("t6_valid", int'(VALID), 0);
    check("t6_dout", int'(DOUT), 0);
    tick(3);
    ACLR_L = 1'b1;
    tick(3);
    check("t6_err", err_cnt - e0, 0);
    READY = 1'b1;
    send(8'h33, 1'b1);
    check("t6_cnt", log_q.size(), 1);
    check("t6_byte", logged(0), 'h33);

    tick(5);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
